packet_deframer: RTL and testbench

- Sits directly downstream of the packet framer and consumes its framed stream: one header word, then payload words, then a footer word marked with lastIn.
- Checks each frame and strips the header and footer, forwarding only payload words.
- Reports a per-packet status pulse and keeps good/bad packet counters for the system's control logic.
- No backpressure exists upstream, so the block accepts a word every cycle in which validIn is high.

---
 rtl/packet_deframer.sv | 151 +++++++++++++++
 tb/tb_packet_deframer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/packet_deframer.sv
// packet_deframer: validates framer output (header/payload/footer), forwards payload only,
// and reports per-packet status with saturating good/bad packet counters.
module packet_deframer #(
  parameter logic [31:0] FOOTER_WORD = 32'hFFFFFFFF,
  parameter int          MAX_WORDS   = 381,
  parameter int          CNT_W       = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [31:0]      dataIn,
  input  logic             validIn,
  input  logic             lastIn,
  output logic [31:0]      dataOut,
  output logic             validOut,
  output logic             lastOut,
  output logic             stat_valid,
  output logic             stat_ok,
  output logic             stat_err_len,
  output logic             stat_err_footer,
  output logic             stat_err_seq,
  output logic [15:0]      stat_seq,
  output logic [16:0]      stat_len,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] bad_count
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, FOOTER, DRAIN} state_t;
  state_t state, state_n;
  logic [16:0] rem, rem_n, len_r, len_n, hdr_len, o_ln;
  logic [15:0] seq_r, seq_n, exp_seq, exp_n, o_sq;
  logic e_len, e_foot, e_seq, el_n, ef_n, es_n;
  logic emit, o_len, o_foot, o_seq, o_ok;
  logic [31:0] dout_n;
  logic vout_n, lout_n;
  assign hdr_len = {1'b0, dataIn[15:0]} + 17'd1;
  assign o_ok = !(o_len || o_foot || o_seq);
  always_comb begin
    state_n = state;
    rem_n = rem;
    len_n = len_r;
    seq_n = seq_r;
    exp_n = exp_seq;
    el_n = e_len;
    ef_n = e_foot;
    es_n = e_seq;
    dout_n = dataOut;
    vout_n = 1'b0;
    lout_n = 1'b0;
    emit = 1'b0;
    o_len = e_len;
    o_foot = e_foot;
    o_seq = e_seq;
    o_sq = seq_r;
    o_ln = len_r;
    if (validIn) begin
      case (state)
        IDLE: begin
          if (lastIn) begin
            emit = 1'b1;
            o_len = 1'b1;
            o_foot = 1'b0;
            o_seq = 1'b0;
            o_sq = 16'd0;
            o_ln = 17'd0;
          end else begin
            seq_n = dataIn[31:16];
            len_n = hdr_len;
            rem_n = hdr_len;
            es_n = dataIn[31:16] != exp_seq;
            exp_n = dataIn[31:16] + 16'd1;
            ef_n = 1'b0;
            el_n = hdr_len > 17'(MAX_WORDS);
            state_n = (hdr_len > 17'(MAX_WORDS)) ? DRAIN : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (lastIn) begin
            emit = 1'b1;
            o_len = 1'b1;
            o_foot = dataIn != FOOTER_WORD;
            state_n = IDLE;
          end else begin
            dout_n = dataIn;
            vout_n = 1'b1;
            lout_n = rem == 17'd1;
            rem_n = rem - 17'd1;
            state_n = (rem == 17'd1) ? FOOTER : PAYLOAD;
          end
        end
        FOOTER: begin
          // a non-last word here means the frame overran its declared length
          emit = lastIn;
          o_foot = dataIn != FOOTER_WORD;
          el_n = !lastIn || e_len;
          state_n = lastIn ? IDLE : DRAIN;
        end
        DRAIN: begin
          emit = lastIn;
          state_n = lastIn ? IDLE : DRAIN;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      rem <= '0;
      len_r <= '0;
      seq_r <= '0;
      exp_seq <= '0;
      e_len <= 1'b0;
      e_foot <= 1'b0;
      e_seq <= 1'b0;
      dataOut <= '0;
      validOut <= 1'b0;
      lastOut <= 1'b0;
      stat_valid <= 1'b0;
      stat_ok <= 1'b0;
      stat_err_len <= 1'b0;
      stat_err_footer <= 1'b0;
      stat_err_seq <= 1'b0;
      stat_seq <= '0;
      stat_len <= '0;
      good_count <= '0;
      bad_count <= '0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      len_r <= len_n;
      seq_r <= seq_n;
      exp_seq <= exp_n;
      e_len <= el_n;
      e_foot <= ef_n;
      e_seq <= es_n;
      dataOut <= dout_n;
      validOut <= vout_n;
      lastOut <= lout_n;
      stat_valid <= emit;
      if (emit) begin
        stat_ok <= o_ok;
        stat_err_len <= o_len;
        stat_err_footer <= o_foot;
        stat_err_seq <= o_seq;
        stat_seq <= o_sq;
        stat_len <= o_ln;
        if (o_ok && good_count != '1) good_count <= good_count + 1'b1;
        if (!o_ok && bad_count != '1) bad_count <= bad_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_packet_deframer.sv
// tb_packet_deframer: scoreboard bench; expected payload and status are queued as frames are driven.
module tb_packet_deframer;
  logic clock = 0, resetn = 0, validIn = 0, lastIn = 0;
  logic [31:0] dataIn = '0, dataOut;
  logic validOut, lastOut, stat_valid, stat_ok, stat_err_len, stat_err_footer, stat_err_seq;
  logic [15:0] stat_seq, good_count, bad_count;
  logic [16:0] stat_len;
  int vectors = 0, miscompares = 0;
  logic [32:0] dq[$];
  logic [36:0] sq[$];
  packet_deframer dut (
    .clock(clock), .resetn(resetn), .dataIn(dataIn), .validIn(validIn), .lastIn(lastIn),
    .dataOut(dataOut), .validOut(validOut), .lastOut(lastOut), .stat_valid(stat_valid),
    .stat_ok(stat_ok), .stat_err_len(stat_err_len), .stat_err_footer(stat_err_footer),
    .stat_err_seq(stat_err_seq), .stat_seq(stat_seq), .stat_len(stat_len),
    .good_count(good_count), .bad_count(bad_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic put(input logic [31:0] d, input logic l);
    dataIn = d;
    lastIn = l;
    validIn = 1;
    @(posedge clock); #1;
    validIn = 0;
    lastIn = 0;
    if ($urandom_range(3) == 0) begin
      @(posedge clock); #1;
    end
  endtask
  task automatic pay(input logic [31:0] d, input logic l);
    dq.push_back({l, d});
    put(d, 1'b0);
  endtask
  task automatic exp_st(input logic ok, el, ef, es, input logic [15:0] s, input logic [16:0] n);
    sq.push_back({ok, el, ef, es, s, n});
  endtask
  task automatic settle();
    repeat (2) @(posedge clock);
    #1;
  endtask
  always @(negedge clock) if (resetn) begin
    if (validOut) begin
      if (dq.size() == 0) chk("data_spurious", validOut, 0);
      else chk("data", {lastOut, dataOut}, dq.pop_front());
    end
    if (stat_valid) begin
      if (sq.size() == 0) chk("stat_spurious", stat_valid, 0);
      else chk("status", {stat_ok, stat_err_len, stat_err_footer, stat_err_seq, stat_seq, stat_len}, sq.pop_front());
    end
  end
  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outs", {dataOut, validOut, lastOut, stat_valid, stat_ok, stat_err_len, stat_err_footer,
                       stat_err_seq, stat_seq, stat_len, good_count, bad_count}, 0);
    resetn = 1;
    @(posedge clock); #1;
    // clean three-word frame
    exp_st(1, 0, 0, 0, 16'd0, 17'd3);
    put(32'h0000_0002, 0);
    pay(32'hA, 0);
    pay(32'hB, 0);
    pay(32'hC, 1);
    put(32'hFFFF_FFFF, 1);
    settle();
    chk("good_t1", good_count, 1);
    // sequence continuity, jump, then resync
    foreach (sq[i]) ;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] s;
      s = (k == 0) ? 16'd1 : (k == 1) ? 16'd5 : 16'd6;
      exp_st(k != 1, 0, 0, k == 1, s, 17'd1);
      put({s, 16'h0000}, 0);
      pay(32'h100 + k, 1);
      put(32'hFFFF_FFFF, 1);
    end
    settle();
    chk("good_t2", good_count, 3);
    chk("bad_t2", bad_count, 1);
    // early end: 4 declared, 2 sent; seq 1 also mismatches expected 7
    exp_st(0, 1, 0, 1, 16'd1, 17'd4);
    put(32'h0001_0003, 0);
    pay(32'h11, 0);
    pay(32'h22, 0);
    put(32'hFFFF_FFFF, 1);
    // bad footer
    exp_st(0, 0, 1, 0, 16'd2, 17'd1);
    put(32'h0002_0000, 0);
    pay(32'hA, 1);
    put(32'h1234_5678, 1);
    // over MAX_WORDS: drained, nothing forwarded
    exp_st(0, 1, 0, 0, 16'd3, 17'd382);
    put(32'h0003_017D, 0);
    for (int i = 0; i < 3; i++) put(32'h55 + i, 0);
    put(32'hFFFF_FFFF, 1);
    settle();
    chk("bad_t5", bad_count, 4);
    // exactly MAX_WORDS is legal
    exp_st(1, 0, 0, 0, 16'd4, 17'd381);
    put(32'h0004_017C, 0);
    for (int i = 0; i < 381; i++) pay(32'h1000 + i, i == 380);
    put(32'hFFFF_FFFF, 1);
    // runt frame
    exp_st(0, 1, 0, 0, 16'd0, 17'd0);
    put(32'hFFFF_FFFF, 1);
    // frame longer than declared
    exp_st(0, 1, 0, 0, 16'd5, 17'd1);
    put(32'h0005_0000, 0);
    pay(32'h77, 1);
    put(32'h88, 0);
    put(32'hFFFF_FFFF, 1);
    settle();
    chk("good_t6", good_count, 4);
    chk("bad_t6", bad_count, 6);
    // reset mid-payload: no status for abandoned frame
    put(32'h0006_0003, 0);
    pay(32'h99, 0);
    pay(32'h9A, 0);
    @(negedge clock); #1;
    resetn = 0;
    @(posedge clock); #1;
    chk("rst_counts", {good_count, bad_count, stat_valid, validOut}, 0);
    resetn = 1;
    @(posedge clock); #1;
    exp_st(1, 0, 0, 0, 16'd0, 17'd2);
    put(32'h0000_0001, 0);
    pay(32'hD0, 0);
    pay(32'hD1, 1);
    put(32'hFFFF_FFFF, 1);
    settle();
    chk("good_final", good_count, 1);
    chk("bad_final", bad_count, 0);
    chk("pending_data", dq.size(), 0);
    chk("pending_stat", sq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
